fifo_sync_param: RTL
====================

Name: fifo_sync_param

Overview:
- Parametrised single-clock synchronous FIFO. Successor to the depth-1 holding buffer.
- Configurable width and depth, with first-word-fall-through read data.
- Provides almost-full and almost-empty thresholds, an occupancy count, and overflow/underflow error pulses.
- Sits between same-clock producer/consumer stages (e.g. 41-bit request/response paths). No clock-domain crossing.

Parameters:
- WIDTH, 41, data word width in bits (>=1).
- DEPTH, 4, number of entries (>=2; need not be a power of two).
- AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).
- CW, $clog2(DEPTH+1), derived count width; not to be overridden.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous, active-low reset; deassertion is synchronous to clk externally.
- data_in  input  WIDTH  write data, sampled on clk when a write is accepted.
- write_enable  input  1  write request.
- read_enable  input  1  read/pop request; pops the entry currently on data_out.
- data_out  output  WIDTH  head entry (FWFT); 0 while empty.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- count  output  CW  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse: write rejected because FIFO was full.
- underflow  output  1  one-cycle pulse: read rejected because FIFO was empty.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Write pointer, read pointer and count go to 0.
  - overflow and underflow go to 0.
  - Outputs are therefore empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0), data_out=0.
  - Storage array is not reset.
- Reset mid-operation: all in-flight contents are discarded. The first valid write after release is the next head.
- Accept rules, evaluated on the current-cycle count:
  - wr_ok = write_enable && (!full || read_enable).
  - rd_ok = read_enable && !empty.
- Write while full with a simultaneous read is accepted: the pop frees the slot in the same edge.
- Read while empty with a simultaneous write: the write is accepted, the read is rejected, and underflow pulses. Data does not bypass to the reader in the same cycle.
- On an accepted write: mem[wr_ptr] <= data_in; wr_ptr advances.
- On an accepted read: rd_ptr advances.
- Pointer wrap: a pointer equal to DEPTH-1 goes to 0 on advance. Modulo-DEPTH arithmetic, no power-of-two assumption.
- Count update each edge: count <= count + wr_ok - rd_ok. Both accepted means count is unchanged. Count never exceeds DEPTH and never goes below 0.
- Latency:
  - Write to visibility is 1 cycle. A word written into an empty FIFO appears on data_out, with empty=0, in the cycle after the write edge.
  - Read is FWFT. data_out = mem[rd_ptr] combinationally whenever !empty, and the consumer takes it in the same cycle it asserts read_enable. The next entry, or 0 if the FIFO becomes empty, appears after the edge.
- All flag outputs (full, empty, almost_*) are combinational decodes of registered count. There are no combinational paths from write_enable/read_enable to any output.
- Error pulses:
  - overflow is registered and high for exactly the one cycle after an edge where write_enable && full && !read_enable.
  - underflow is registered and high for the one cycle after an edge where read_enable && empty.
  - Rejected operations change no state other than these pulses.
- DEPTH=1-style use is out of scope. DEPTH<2 or out-of-range thresholds are illegal; flag them with elaboration-time checks.

Test Plan:
1. Reset, then 4 writes 0x1,0x2,0x3,0x4 (DEPTH=4) -> count 1..4 on successive cycles; almost_full at count 3; full at 4. Four reads return 0x1..0x4 in order; empty=1 and data_out=0 afterwards.
2. Full FIFO, write 0x5 without read -> overflow pulses for 1 cycle, count stays 4, contents unchanged. Then write 0x6 with simultaneous read -> pops 0x1, accepts 0x6, count stays 4, no overflow.
3. Empty FIFO, read alone -> underflow for 1 cycle, count 0. Then read+write of 0xA together -> underflow pulses, count 1, and next cycle data_out=0xA.
4. DEPTH=3 (non-power-of-two): 10 continuous write/read pairs with a standing occupancy of 2 -> pointers wrap 2->0, data order preserved, count steady at 2.
5. Fill to 3 entries, then assert rst_n low asynchronously mid-cycle -> outputs immediately empty=1, count=0, data_out=0. After release, a write of 0x7 becomes head, with no stale data.
6. AF_LEVEL=2, AE_LEVEL=0 override: fill and drain -> almost_full set at count>=2, almost_empty only at count 0.

Source files
------------

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parametrised single-clock FWFT FIFO with thresholds and error pulses
module fifo_sync_param #(
  parameter int WIDTH    = 41,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  parameter int CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             write_enable,
  input  logic             read_enable,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  // Pointer width; DEPTH need not be a power of two, so pointers wrap explicitly.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  // Illegal configurations are rejected at elaboration.
  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_sync_param: DEPTH must be >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_sync_param: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("fifo_sync_param: AE_LEVEL must be in 0..DEPTH-1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("fifo_sync_param: WIDTH must be >= 1");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  function automatic logic [PW-1:0] advance(input logic [PW-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
  endfunction

  // Flags decode only the registered count; no enable-to-output paths.
  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  // A full FIFO still accepts a write when the same edge pops the head.
  assign wr_ok = write_enable && (!full || read_enable);
  assign rd_ok = read_enable && !empty;

  // First-word-fall-through head; forced to zero so stale storage never shows.
  assign data_out = empty ? '0 : mem[rd_ptr];

  // Storage array is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy and one-cycle error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= advance(wr_ptr);
      end
      if (rd_ok) begin
        rd_ptr <= advance(rd_ptr);
      end
      if (wr_ok && !rd_ok) begin
        count <= count + CW'(1);
      end else if (rd_ok && !wr_ok) begin
        count <= count - CW'(1);
      end
      overflow  <= write_enable && full && !read_enable;
      underflow <= read_enable && empty;
    end
  end

endmodule
